// File: rtl/pipe_shifter_if.sv
// Operand/result bundle for pipe_shifter.
//   master : drives the operand and out_rdy, observes in_rdy and the result.
//   slave  : the shifter itself.
//   in_vld/in_rdy/in_data/in_shamt/in_mode : operand channel.
//   out_vld/out_rdy/out_data/out_carry/out_zero : result channel.
interface pipe_shifter_if #(
  parameter int unsigned WIDTH = 16
) ();
  localparam int unsigned SW = $clog2(WIDTH);

  logic             in_vld;
  logic             in_rdy;
  logic [WIDTH-1:0] in_data;
  logic [SW-1:0]    in_shamt;
  logic [1:0]       in_mode;
  logic             out_vld;
  logic             out_rdy;
  logic [WIDTH-1:0] out_data;
  logic             out_carry;
  logic             out_zero;

  modport master (
    output in_vld, in_data, in_shamt, in_mode, out_rdy,
    input  in_rdy, out_vld, out_data, out_carry, out_zero
  );

  modport slave (
    input  in_vld, in_data, in_shamt, in_mode, out_rdy,
    output in_rdy, out_vld, out_data, out_carry, out_zero
  );
endinterface

// File: rtl/pipe_shifter.sv
// Pipelined barrel shifter (SLL / SRL / SRA / ROR) with valid/ready flow control.
// The log2(WIDTH) shift levels are spread over PIPE register stages; latency is PIPE.
//   clk  : clock, rising edge.
//   rst  : asynchronous active-high reset, clears every stage.
//   bus  : pipe_shifter_if slave (operand in, result + carry/zero flags out).
module pipe_shifter #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned PIPE  = 2
) (
  input logic           clk,
  input logic           rst,
  pipe_shifter_if.slave bus
);
  localparam int unsigned SW   = $clog2(WIDTH);
  // The last stage never needs shamt/mode, so only the inner stages keep them.
  localparam int unsigned NMID = (PIPE > 1) ? PIPE - 1 : 1;

  localparam logic [1:0] MODE_SLL = 2'b00;
  localparam logic [1:0] MODE_SRL = 2'b01;
  localparam logic [1:0] MODE_SRA = 2'b10;
  localparam logic [1:0] MODE_ROR = 2'b11;

  logic [PIPE-1:0]  vld_q;
  logic [WIDTH-1:0] data_q  [PIPE];
  logic [PIPE-1:0]  carry_q;
  logic [SW-1:0]    shamt_q [NMID];
  logic [1:0]       mode_q  [NMID];
  logic             zero_q;

  logic [PIPE-1:0]  vld_d;
  logic [WIDTH-1:0] data_d  [PIPE];
  logic [PIPE-1:0]  carry_d;
  logic [SW-1:0]    shamt_d [NMID];
  logic [1:0]       mode_d  [NMID];

  logic [PIPE:0]    ld_c;

  // Load chain: a stage loads when it is empty or its successor loads this cycle.
  always_comb begin
    ld_c       = '0;
    ld_c[PIPE] = bus.out_rdy;
    for (int k = int'(PIPE) - 1; k >= 0; k--) begin
      ld_c[k] = ~vld_q[k] | ld_c[k+1];
    end
  end

  // Per-stage shift levels; level i lives in stage (i*PIPE)/SW.
  always_comb begin : p_levels
    logic             v;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] tmp;
    logic [SW-1:0]    s;
    logic [SW-1:0]    s_sh;
    logic [1:0]       m;
    logic             c;
    int               n;

    vld_d   = '0;
    carry_d = '0;
    for (int k = 0; k < int'(PIPE); k++) begin
      data_d[k] = '0;
    end
    for (int k = 0; k < int'(NMID); k++) begin
      shamt_d[k] = '0;
      mode_d[k]  = '0;
    end
    v    = 1'b0;
    d    = '0;
    tmp  = '0;
    s    = '0;
    s_sh = '0;
    m    = '0;
    c    = 1'b0;
    n    = 0;

    for (int k = 0; k < int'(PIPE); k++) begin
      if (k == 0) begin
        v = bus.in_vld;
        d = bus.in_data;
        s = bus.in_shamt;
        m = bus.in_mode;
        c = 1'b0;
      end else begin
        v = vld_q[k-1];
        d = data_q[k-1];
        s = shamt_q[k-1];
        m = mode_q[k-1];
        c = carry_q[k-1];
      end

      for (int i = 0; i < int'(SW); i++) begin
        n    = 1 << i;
        s_sh = s >> i;
        if (((i * int'(PIPE)) / int'(SW)) == k && s_sh[0]) begin
          // Each applied level overwrites carry with the last bit it pushes out,
          // so after all levels carry is the last bit out of the total shift.
          case (m)
            MODE_SLL: begin
              tmp = d >> (WIDTH - n);
              c   = tmp[0];
              d   = d << n;
            end
            MODE_SRL: begin
              tmp = d >> (n - 1);
              c   = tmp[0];
              d   = d >> n;
            end
            MODE_SRA: begin
              // Arithmetic shifts preserve the MSB, so it still holds the operand sign.
              tmp = d >> (n - 1);
              c   = tmp[0];
              d   = WIDTH'($signed(d) >>> n);
            end
            MODE_ROR: begin
              tmp = d >> (n - 1);
              c   = tmp[0];
              d   = (d >> n) | (d << (WIDTH - n));
            end
            default: ;
          endcase
        end
      end

      vld_d[k]   = v;
      data_d[k]  = d;
      carry_d[k] = c;
      if (k < int'(PIPE) - 1) begin
        shamt_d[k] = s;
        mode_d[k]  = m;
      end
    end
  end

  // Stage registers; a stage that does not load holds every field.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q   <= '0;
      carry_q <= '0;
      zero_q  <= 1'b0;
      for (int k = 0; k < int'(PIPE); k++) begin
        data_q[k] <= '0;
      end
      for (int k = 0; k < int'(NMID); k++) begin
        shamt_q[k] <= '0;
        mode_q[k]  <= '0;
      end
    end else begin
      for (int k = 0; k < int'(PIPE); k++) begin
        if (ld_c[k]) begin
          vld_q[k]   <= vld_d[k];
          data_q[k]  <= data_d[k];
          carry_q[k] <= carry_d[k];
          if (k < int'(PIPE) - 1) begin
            shamt_q[k] <= shamt_d[k];
            mode_q[k]  <= mode_d[k];
          end
        end
      end
      if (ld_c[PIPE-1]) begin
        zero_q <= (data_d[PIPE-1] == '0);
      end
    end
  end

  assign bus.in_rdy    = ld_c[0];
  assign bus.out_vld   = vld_q[PIPE-1];
  assign bus.out_data  = data_q[PIPE-1];
  assign bus.out_carry = carry_q[PIPE-1];
  assign bus.out_zero  = zero_q;
endmodule

// File: tb/tb_pipe_shifter.sv
// Self-checking bench for pipe_shifter: directed checks on a WIDTH=16/PIPE=2 instance,
// then randomised streams on WIDTH=32 instances with PIPE = 1, 3 and 5.
module tb_pipe_shifter;
  logic clk = 1'b0;
  logic rst;
  int   nvec = 0;
  int   nmis = 0;

  always #5 clk = ~clk;

  pipe_shifter_if #(.WIDTH(16)) b16 ();
  pipe_shifter_if #(.WIDTH(32)) b1 ();
  pipe_shifter_if #(.WIDTH(32)) b3 ();
  pipe_shifter_if #(.WIDTH(32)) b5 ();

  pipe_shifter #(.WIDTH(16), .PIPE(2)) u16 (.clk(clk), .rst(rst), .bus(b16));
  pipe_shifter #(.WIDTH(32), .PIPE(1)) u1  (.clk(clk), .rst(rst), .bus(b1));
  pipe_shifter #(.WIDTH(32), .PIPE(3)) u3  (.clk(clk), .rst(rst), .bus(b3));
  pipe_shifter #(.WIDTH(32), .PIPE(5)) u5  (.clk(clk), .rst(rst), .bus(b5));

  // Reference: {zero, carry, data} computed straight from the operation definitions.
  function automatic logic [33:0] model(input logic [31:0] d, input int s,
                                        input logic [1:0] m, input int w);
    logic [63:0] x;
    logic [63:0] mask;
    logic [63:0] r;
    logic        c;
    mask = (64'd1 << w) - 64'd1;
    x    = {32'd0, d} & mask;
    case (m)
      2'b00:   r = (x << s) & mask;
      2'b01:   r = x >> s;
      2'b10:   r = (x >> s) | (x[w-1] ? (mask & ~(mask >> s)) : 64'd0);
      default: r = ((x >> s) | (x << (w - s))) & mask;
    endcase
    if (s == 0)        c = 1'b0;
    else if (m == 2'b00) c = x[w-s];
    else               c = x[s-1];
    return {(r == 64'd0), c, r[31:0]};
  endfunction

  task automatic chk1(input string tag, input logic obs, input logic exp);
    nvec++;
    assert (obs === exp) else begin
      nmis++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nmis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive the 16-bit instance on the falling edge and let it settle before sampling.
  task automatic drv16(input logic v, input logic [15:0] d, input logic [3:0] s,
                       input logic [1:0] m, input logic ordy);
    @(negedge clk);
    b16.in_vld   = v;
    b16.in_data  = d;
    b16.in_shamt = s;
    b16.in_mode  = m;
    b16.out_rdy  = ordy;
    #1;
  endtask

  task automatic chk_out16(input string tag, input logic [33:0] e);
    chk1({tag, "_vld"}, b16.out_vld, 1'b1);
    chkw({tag, "_data"}, 32'(b16.out_data), e[31:0]);
    chk1({tag, "_carry"}, b16.out_carry, e[32]);
    chk1({tag, "_zero"}, b16.out_zero, e[33]);
  endtask

  // One operand through an empty pipe; result must show after the second edge.
  task automatic basic16(input string tag, input logic [15:0] d, input logic [3:0] s,
                         input logic [1:0] m, input logic [33:0] e);
    drv16(1'b1, d, s, m, 1'b1);
    chk1({tag, "_rdy"}, b16.in_rdy, 1'b1);
    drv16(1'b0, 16'h0, 4'h0, 2'b00, 1'b1);
    chk1({tag, "_early"}, b16.out_vld, 1'b0);
    drv16(1'b0, 16'h0, 4'h0, 2'b00, 1'b1);
    chk_out16(tag, e);
  endtask

  logic [15:0] sd [8];
  logic [3:0]  ss [8];
  logic [1:0]  sm [8];
  logic [33:0] ea, eb, ec, e;

  int          pipes [3] = '{1, 3, 5};
  logic [33:0] expq [3][$];
  int          accq [3][$];
  logic        rv [3];
  logic [31:0] rd [3];
  int          rs [3];
  logic [1:0]  rm [3];
  logic        ro [3];
  logic        ir [3];
  logic        ov [3];
  logic [31:0] od [3];
  logic        oc [3];
  logic        oz [3];
  int          a;
  logic        full_rdy;

  initial begin
    rst = 1'b1;
    b16.in_vld = 1'b0; b16.in_data = '0; b16.in_shamt = '0; b16.in_mode = '0; b16.out_rdy = 1'b0;
    b1.in_vld = 1'b0;  b1.in_data = '0;  b1.in_shamt = '0;  b1.in_mode = '0;  b1.out_rdy = 1'b1;
    b3.in_vld = 1'b0;  b3.in_data = '0;  b3.in_shamt = '0;  b3.in_mode = '0;  b3.out_rdy = 1'b1;
    b5.in_vld = 1'b0;  b5.in_data = '0;  b5.in_shamt = '0;  b5.in_mode = '0;  b5.out_rdy = 1'b1;

    // Reset state
    #7;
    chk1("rst_vld", b16.out_vld, 1'b0);
    chkw("rst_data", 32'(b16.out_data), 32'h0);
    chk1("rst_carry", b16.out_carry, 1'b0);
    chk1("rst_zero", b16.out_zero, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk1("rst_rdy", b16.in_rdy, 1'b1);

    // Basic modes and shamt corners
    basic16("sll", 16'hF00F, 4'd4,  2'b00, {1'b0, 1'b1, 32'h0000_00F0});
    basic16("srl", 16'h8001, 4'd1,  2'b01, {1'b0, 1'b1, 32'h0000_4000});
    basic16("sra", 16'h8000, 4'd15, 2'b10, {1'b0, 1'b0, 32'h0000_FFFF});
    basic16("ror", 16'h1234, 4'd8,  2'b11, {1'b0, 1'b0, 32'h0000_3412});
    basic16("zero", 16'h0001, 4'd1, 2'b01, {1'b1, 1'b1, 32'h0000_0000});
    basic16("sh0", 16'hA5A5, 4'd0,  2'b10, {1'b0, 1'b0, 32'h0000_A5A5});

    // Streaming: 8 back-to-back operands, results on consecutive cycles
    for (int i = 0; i < 8; i++) begin
      sd[i] = 16'($urandom);
      ss[i] = 4'($urandom_range(0, 15));
      sm[i] = 2'($urandom_range(0, 3));
    end
    for (int j = 0; j < 10; j++) begin
      if (j < 8) drv16(1'b1, sd[j], ss[j], sm[j], 1'b1);
      else       drv16(1'b0, 16'h0, 4'h0, 2'b00, 1'b1);
      if (j < 8) chk1("stream_rdy", b16.in_rdy, 1'b1);
      if (j >= 2) begin
        e = model(32'(sd[j-2]), int'(ss[j-2]), sm[j-2], 16);
        chk_out16("stream", e);
      end else begin
        chk1("stream_idle", b16.out_vld, 1'b0);
      end
    end
    drv16(1'b0, 16'h0, 4'h0, 2'b00, 1'b1);
    chk1("stream_done", b16.out_vld, 1'b0);

    // Back-pressure: two fill the pipe, the third waits for release
    ea = model(32'h1234, 3, 2'b00, 16);
    eb = model(32'h8001, 5, 2'b10, 16);
    ec = model(32'h00FF, 4, 2'b11, 16);
    drv16(1'b1, 16'h1234, 4'd3, 2'b00, 1'b0);
    chk1("bp_rdy_a", b16.in_rdy, 1'b1);
    drv16(1'b1, 16'h8001, 4'd5, 2'b10, 1'b0);
    chk1("bp_rdy_b", b16.in_rdy, 1'b1);
    chk1("bp_vld_b", b16.out_vld, 1'b0);
    for (int j = 0; j < 3; j++) begin
      drv16(1'b1, 16'h00FF, 4'd4, 2'b11, 1'b0);
      chk1("bp_full_rdy", b16.in_rdy, 1'b0);
      chk_out16("bp_hold", ea);
    end
    drv16(1'b1, 16'h00FF, 4'd4, 2'b11, 1'b1);
    chk1("bp_release_rdy", b16.in_rdy, 1'b1);
    chk_out16("bp_out_a", ea);
    drv16(1'b0, 16'h0, 4'h0, 2'b00, 1'b1);
    chk_out16("bp_out_b", eb);
    drv16(1'b0, 16'h0, 4'h0, 2'b00, 1'b1);
    chk_out16("bp_out_c", ec);
    drv16(1'b0, 16'h0, 4'h0, 2'b00, 1'b1);
    chk1("bp_empty", b16.out_vld, 1'b0);

    // Reset mid-flight: two operands in the pipe, asynchronous pulse between edges
    drv16(1'b1, 16'hFFFF, 4'd2, 2'b01, 1'b0);
    drv16(1'b1, 16'h7FFF, 4'd1, 2'b00, 1'b0);
    drv16(1'b0, 16'h0, 4'h0, 2'b00, 1'b0);
    chk1("mid_pre_vld", b16.out_vld, 1'b1);
    #1 rst = 1'b1;
    #1;
    chk1("mid_vld", b16.out_vld, 1'b0);
    chkw("mid_data", 32'(b16.out_data), 32'h0);
    chk1("mid_carry", b16.out_carry, 1'b0);
    chk1("mid_zero", b16.out_zero, 1'b0);
    #1 rst = 1'b0;
    for (int j = 0; j < 4; j++) begin
      drv16(1'b0, 16'h0, 4'h0, 2'b00, 1'b1);
      chk1("mid_no_stale", b16.out_vld, 1'b0);
      chk1("mid_rdy", b16.in_rdy, 1'b1);
    end

    // Randomised streams on WIDTH=32, PIPE=1/3/5
    for (int t = 0; t < 4600; t++) begin
      full_rdy = (t < 1500) || (t >= 4500);
      @(negedge clk);
      for (int j = 0; j < 3; j++) begin
        rv[j] = (t < 4500) && ($urandom_range(0, 3) != 0);
        rd[j] = $urandom;
        rs[j] = int'($urandom_range(0, 31));
        rm[j] = 2'($urandom_range(0, 3));
        ro[j] = full_rdy ? 1'b1 : ($urandom_range(0, 2) != 0);
      end
      b1.in_vld = rv[0]; b1.in_data = rd[0]; b1.in_shamt = 5'(rs[0]); b1.in_mode = rm[0]; b1.out_rdy = ro[0];
      b3.in_vld = rv[1]; b3.in_data = rd[1]; b3.in_shamt = 5'(rs[1]); b3.in_mode = rm[1]; b3.out_rdy = ro[1];
      b5.in_vld = rv[2]; b5.in_data = rd[2]; b5.in_shamt = 5'(rs[2]); b5.in_mode = rm[2]; b5.out_rdy = ro[2];
      #1;
      ir[0] = b1.in_rdy; ov[0] = b1.out_vld; od[0] = b1.out_data; oc[0] = b1.out_carry; oz[0] = b1.out_zero;
      ir[1] = b3.in_rdy; ov[1] = b3.out_vld; od[1] = b3.out_data; oc[1] = b3.out_carry; oz[1] = b3.out_zero;
      ir[2] = b5.in_rdy; ov[2] = b5.out_vld; od[2] = b5.out_data; oc[2] = b5.out_carry; oz[2] = b5.out_zero;
      for (int j = 0; j < 3; j++) begin
        if (ov[j] && ro[j]) begin
          chk1($sformatf("rnd_p%0d_expected", pipes[j]), expq[j].size() != 0, 1'b1);
          if (expq[j].size() != 0) begin
            e = expq[j].pop_front();
            a = accq[j].pop_front();
            chkw($sformatf("rnd_p%0d_data", pipes[j]), od[j], e[31:0]);
            chk1($sformatf("rnd_p%0d_carry", pipes[j]), oc[j], e[32]);
            chk1($sformatf("rnd_p%0d_zero", pipes[j]), oz[j], e[33]);
            if (t < 1500) chkw($sformatf("rnd_p%0d_latency", pipes[j]), 32'(t - a), 32'(pipes[j]));
          end
        end
        if (rv[j] && ir[j]) begin
          expq[j].push_back(model(rd[j], rs[j], rm[j], 32));
          accq[j].push_back(t);
        end
      end
    end
    for (int j = 0; j < 3; j++) begin
      chkw($sformatf("rnd_p%0d_drained", pipes[j]), 32'(expq[j].size()), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
